// File: rtl/pdh_sample_packer.sv
`default_nettype none
// ============================================================================
// Module      : pdh_sample_packer
// Description : Feeds dma_controller with sample data. It decimates the
//               16-bit A/B sample pairs, packs two kept pairs into each 64-bit
//               word and buffers the words in a first-word-fall-through FIFO.
//               The FIFO is read through a valid/ready word stream.
//               burst_avail_o is high when the FIFO holds at least one full
//               DMA burst.
// Ports       : aclk, rst_i (async, active-high)
//               enable_i, clear_i, decim_i         - capture control
//               sample_a_i, sample_b_i, sample_valid_i - sample pair input
//               word_o, word_valid_o, word_ready_i - FIFO head stream
//               burst_avail_o, level_o, overflow_o - FIFO status
// Revision    : 1.0 - initial release
// ============================================================================
module pdh_sample_packer #(
  parameter int FIFO_DEPTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int DECIM_W    = 16
) (
  input  logic                          aclk,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [DECIM_W-1:0]            decim_i,
  input  logic [15:0]                   sample_a_i,
  input  logic [15:0]                   sample_b_i,
  input  logic                          sample_valid_i,
  output logic [63:0]                   word_o,
  output logic                          word_valid_o,
  input  logic                          word_ready_i,
  output logic                          burst_avail_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;

  localparam logic [c_LVL_W-1:0] c_DEPTH   = FIFO_DEPTH[c_LVL_W-1:0];
  localparam logic [c_LVL_W-1:0] c_BURST   = BURST_LEN[c_LVL_W-1:0];
  localparam logic [c_LVL_W-1:0] c_LVL_ONE = {{(c_LVL_W-1){1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{(c_PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DECIM_W-1:0] c_CNT_ONE = {{(DECIM_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_LO = 2'd1,
    RUN_HI = 2'd2
  } state_t;

  state_t               r_state;
  logic [DECIM_W-1:0]   r_cnt;
  logic [31:0]          r_half;

  logic [63:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_LVL_W-1:0]   r_level;
  logic                 r_overflow;
  logic                 r_burst;

  logic                 w_running;
  logic                 w_accept;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;
  logic [c_LVL_W-1:0]   w_level_next;
  logic [63:0]          w_push_word;

  // A pair can only be taken while already in a run state with enable still
  // high; the IDLE->RUN_LO cycle never accepts.
  assign w_running   = (r_state != IDLE) && enable_i && !clear_i;
  assign w_accept    = w_running && sample_valid_i && (r_cnt == '0);
  assign w_push_req  = w_accept && (r_state == RUN_HI);
  assign w_push_word = {sample_a_i, sample_b_i, r_half};

  // A pop at full frees the slot the simultaneous push lands in, so the push
  // goes through and only a push without a pop at full is dropped.
  assign w_pop  = (r_level != '0) && word_ready_i && !clear_i;
  assign w_full = (r_level == c_DEPTH);
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + c_LVL_ONE;
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - c_LVL_ONE;
    end
  end

  // Capture FSM: decimation counter and half-word register.
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
    end else if (clear_i) begin
      r_state <= enable_i ? RUN_LO : IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
    end else if (!enable_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_half  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN_LO;
        end
        RUN_LO, RUN_HI: begin
          if (sample_valid_i) begin
            if (r_cnt == '0) begin
              // Ratio is picked up at every reload, so a new decim_i takes
              // effect after the next accepted pair.
              r_cnt <= decim_i;
              if (r_state == RUN_LO) begin
                r_half  <= {sample_a_i, sample_b_i};
                r_state <= RUN_HI;
              end else begin
                r_state <= RUN_LO;
              end
            end else begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage has no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_burst    <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
      r_burst    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_level <= w_level_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_burst <= (w_level_next >= c_BURST);
    end
  end

  assign word_valid_o  = (r_level != '0);
  assign word_o        = word_valid_o ? r_mem[r_rd_ptr] : '0;
  assign level_o       = r_level;
  assign overflow_o    = r_overflow;
  assign burst_avail_o = r_burst;

endmodule
`default_nettype wire
